// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared FSM state encoding and counter-width helper for the serial arithmetic blocks
package arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bits needed to count 0..w-1; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_subtractor_1bit.sv
// rtl/full_subtractor_1bit.sv - combinational 1-bit full subtractor cell (A - B - Bin)
module full_subtractor_1bit (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic Diff,
    output logic Bout
);

    assign Diff = A ^ B ^ Bin;
    assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/nbit_serial_subtractor.sv
// rtl/nbit_serial_subtractor.sv - bit-serial WIDTH-bit subtractor, LSB first; SERIAL_SUB_OVF_EN adds a signed-overflow output Ovf
module nbit_serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             Bin,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sha_q, sha_d;
    logic [WIDTH-1:0] shb_q, shb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic             d_bit;
    logic             b_out;
    logic [WIDTH-1:0] res_next;

    full_subtractor_1bit u_cell (
        .A    (sha_q[0]),
        .B    (shb_q[0]),
        .Bin  (br_q),
        .Diff (d_bit),
        .Bout (b_out)
    );

    // New difference bit enters at the MSB so the result lands LSB-aligned after WIDTH steps.
    assign res_next = {d_bit, {(WIDTH-1){1'b0}}} | (res_q >> 1);

    always_comb begin
        state_d = state_q;
        sha_d   = sha_q;
        shb_d   = shb_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        done_d  = 1'b0;
        diff_d  = diff_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sha_d   = A;
                    shb_d   = B;
                    br_d    = Bin;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                br_d  = b_out;
                res_d = res_next;
                sha_d = sha_q >> 1;
                shb_d = shb_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    diff_d  = res_next;
                    bout_d  = b_out;
                    done_d  = 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                    // br_q is the borrow into the MSB, b_out the borrow out of it.
                    ovf_d   = br_q ^ b_out;
`endif
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sha_q   <= '0;
            shb_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sha_q   <= sha_d;
            shb_q   <= shb_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            done_q  <= done_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign Diff = diff_q;
    assign Bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign Ovf  = ovf_q;
`endif

endmodule
